// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider controller.
// DIV_WIDTH is the default operand width; DIV_LAT is start-to-done latency in cycles.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int ITER_CNT_W = $clog2(DIV_WIDTH);
    localparam int DIV_LAT    = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div_ctrl_if #(parameter int WIDTH = 32);

    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op_signed, dividend, divisor,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op_signed, dividend, divisor,
        output busy, done, hi, lo, div_zero
    );

endinterface

// File: rtl/div_core.sv
// Unsigned restoring divide datapath: one subtract/restore/shift per step.
// After WIDTH steps, quotient and remainder hold the unsigned result.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The remainder stays below the divisor, so the shifted value and difference fit in WIDTH+1 bits.
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dvs_reg <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_reg <= diff[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_reg <= shifted[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: FSM, iteration counter, signed fix-up and HI/LO registers.
// Define DIV_FAST_ZERO_EN to let a zero dividend skip the RUN iterations.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH           = DIV_WIDTH,
    parameter bit DIV_ZERO_STICKY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    div_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sgn_reg;
    logic             q_neg;
    logic             r_neg;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             zero_trap;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             div_zero_reg;

    assign a_abs = (sgn_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_abs = (sgn_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_trap = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        zero_trap = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = PREP;
                    end
                end
            end
            PREP: begin
                core_load = 1'b1;
                state_nxt = RUN;
`ifdef DIV_FAST_ZERO_EN
                if (a_reg == '0) state_nxt = FIX;
`endif
            end
            RUN: begin
                core_step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Signs are resolved when the core loads; the fix-up undoes them on the way into HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sgn_reg      <= 1'b0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            cnt          <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg   <= bus.dividend;
                b_reg   <= bus.divisor;
                sgn_reg <= bus.op_signed;
            end
            if (core_load) begin
                q_neg <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                r_neg <= sgn_reg & a_reg[WIDTH-1];
                cnt   <= '0;
            end
            if (core_step) cnt <= cnt + CNT_W'(1);
            if (state == FIX) begin
                lo_reg <= q_neg ? -quotient : quotient;
                hi_reg <= r_neg ? -remainder : remainder;
            end
            done_reg <= (state == FIX);
            if (DIV_ZERO_STICKY) begin
                if (accept)         div_zero_reg <= 1'b0;
                else if (zero_trap) div_zero_reg <= 1'b1;
            end else begin
                div_zero_reg <= zero_trap;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against a 64-bit arithmetic reference.
// Build with DIV_FAST_ZERO_EN defined to expect the short zero-dividend latency.
module tb_div_ctrl;
    import div_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(DIV_WIDTH)) bus();

    div_ctrl #(.WIDTH(DIV_WIDTH), .DIV_ZERO_STICKY(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: sign- or zero-extend to 64 bits so that even MIN/-1 divides without overflow.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int expectedLat(input logic [31:0] a);
        bit fastZero = 1'b0;
`ifdef DIV_FAST_ZERO_EN
        fastZero = 1'b1;
`endif
        if (fastZero && a == 32'd0) return 2;
        return DIV_LAT;
    endfunction

    // Called on a falling edge; returns on the falling edge where done is seen.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input bit injectStart, input string tag);
        logic [63:0] expv;
        int          lat;
        int          k;
        int          busyCycles;
        bit          seen;
        expv          = refDiv(a, b, sgn);
        lat           = expectedLat(a);
        bus.start     = 1'b1;
        bus.op_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.op_signed = 1'($urandom_range(0, 1));
        k          = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (!seen && k <= 3 * DIV_LAT) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busyCycles++;
                bus.start = (injectStart && k == 10 && lat > 10);
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(k), 64'(lat));
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'(lat));
        checkOutput({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(expv[31:0]));
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(expv[63:32]));
        checkOutput({tag, "_div_zero"}, 64'(bus.div_zero), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        $display("[TB] starting div_ctrl bench");
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_div_zero", 64'(bus.div_zero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        @(negedge clk);
        checkOutput("done_single_pulse", 64'(bus.done), 64'd0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
        @(negedge clk);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "div_7_m2");
        @(negedge clk);

        applyStimulus(32'h352, 32'h30, 1'b0, 1'b0, "divu_setup_11_22");
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_signed = 1'b0;
        bus.dividend  = 32'd5;
        bus.divisor   = 32'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("zero_div_zero", 64'(bus.div_zero), 64'd1);
        checkOutput("zero_busy", 64'(bus.busy), 64'd0);
        checkOutput("zero_done", 64'(bus.done), 64'd0);
        checkOutput("zero_hi_kept", 64'(bus.hi), 64'h22);
        checkOutput("zero_lo_kept", 64'(bus.lo), 64'h11);
        @(negedge clk);
        checkOutput("zero_pulse_ends", 64'(bus.div_zero), 64'd0);
        checkOutput("zero_no_late_done", 64'(bus.done), 64'd0);
        checkOutput("zero_stays_idle", 64'(bus.busy), 64'd0);

        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_overflow");
        @(negedge clk);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_max_1");
        @(negedge clk);
        applyStimulus(32'd12345, 32'd67, 1'b0, 1'b1, "divu_ignored_start");
        @(negedge clk);

        applyStimulus(32'd1000, 32'd33, 1'b0, 1'b0, "b2b_first");
        applyStimulus(32'hFFFF_F000, 32'd9, 1'b1, 1'b0, "b2b_second");
        @(negedge clk);

        // Abort in the 15th RUN cycle; RUN begins on the cycle after PREP.
        bus.start     = 1'b1;
        bus.op_signed = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_hi", 64'(bus.hi), 64'd0);
        checkOutput("abort_lo", 64'(bus.lo), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        repeat (DIV_LAT) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(bus.done), 64'd0);
        end

        applyStimulus(32'd0, 32'd9, 1'b0, 1'b0, "zero_dividend");
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            rb = 32'($urandom) >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
